// File: rtl/rs_syn_mc.sv
// rs_syn_mc: multi-channel serial Reed-Solomon syndrome calculator.
// Channel-interleaved symbols arrive highest degree first. Each channel keeps its
// own Horner accumulator bank. On end-of-packet the CHECK syndromes, the channel,
// a length-error flag and (optionally) erasure data load one output register,
// which is offered downstream with valid/ready.
// Optional feature macro: RS_SYN_ERASURE_EN enables per-channel erasure tracking;
// without it out_eracnt_o and out_erapos_o are tied to zero.
//
// Handshake: a beat transfers on a rising edge where in_valid_i & in_ready_o; a
// record transfers on a rising edge where out_valid_o & out_ready_i. A producer
// holding valid keeps its payload stable until the transfer. in_ready_o is
// combinational (!out_valid_o | out_ready_i) and is low while rst_ni is low.
module rs_syn_mc #(
  parameter int BITSPERSYMBOL = 8,
  parameter int CHECK         = 32,
  parameter int IRRPOL        = 285,
  parameter int N             = 255,
  parameter int GENSTART      = 0,
  parameter int ROOTSPACE     = 1,
  parameter int CHANNELS      = 4,
  localparam int M            = BITSPERSYMBOL,
  localparam int CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_sop_i,
  input  logic               in_eop_i,
  input  logic [CHW-1:0]     in_channel_i,
  input  logic [M-1:0]       in_data_i,
  input  logic               in_erasure_i,
  input  logic [7:0]         in_numn_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CHW-1:0]     out_channel_o,
  output logic [CHECK*M-1:0] out_synd_o,
  output logic               out_len_err_o,
  output logic [7:0]         out_eracnt_o,
  output logic [N-1:0]       out_erapos_o
);

  localparam logic [M-1:0] POLY    = M'(IRRPOL);
  localparam int           ORDER   = (1 << M) - 1;
  localparam logic [8:0]   CNT_MAX = 9'(N + 1);

  // Multiply by alpha, reducing with the field polynomial.
  function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
  endfunction

  // General GF(2^M) multiply; with a constant operand it folds to an XOR network.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    p = '0;
    for (int i = M - 1; i >= 0; i--) begin
      p = gf_xtime(p);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  // Root r_j = alpha^((GENSTART+j)*ROOTSPACE), evaluated at elaboration.
  function automatic logic [M-1:0] gf_root(input int j);
    logic [M-1:0] r;
    int           e;
    r    = '0;
    r[0] = 1'b1;
    e    = ((GENSTART + j) * ROOTSPACE) % ORDER;
    for (int k = 0; k < ORDER; k++) begin
      if (k < e) r = gf_xtime(r);
    end
    return r;
  endfunction

  // Per-channel state
  logic [M-1:0]        acc_q   [CHANNELS][CHECK];
  logic [8:0]          count_q [CHANNELS];
  logic [7:0]          numn_q  [CHANNELS];
  logic [CHANNELS-1:0] active_q;

  // Output record register
  logic               out_valid_q;
  logic [CHW-1:0]     out_channel_q;
  logic [CHECK*M-1:0] out_synd_q;
  logic               out_len_err_q;

  // Next values for the channel addressed by the current beat
  logic [M-1:0] acc_d [CHECK];
  logic [8:0]   count_d;
  logic [7:0]   numn_d;
  logic         fire;
  logic         ch_ok;
  logic         upd;
  logic         eop_hit;
  logic         len_err_d;

  assign in_ready_o = rst_ni & (~out_valid_q | out_ready_i);
  assign fire       = in_valid_i & in_ready_o;
  assign ch_ok      = int'(in_channel_i) < CHANNELS;

  for (genvar j = 0; j < CHECK; j++) begin : g_root
    localparam logic [M-1:0] ROOT = gf_root(j);
    assign acc_d[j] = in_sop_i ? in_data_i
                               : (gf_mul(acc_q[in_channel_i][j], ROOT) ^ in_data_i);
  end

  // Beat qualification, saturating beat count and length check for the addressed channel.
  always_comb begin
    upd     = fire & ch_ok & (in_sop_i | active_q[in_channel_i]);
    eop_hit = upd & in_eop_i;
    numn_d  = in_sop_i ? in_numn_i : numn_q[in_channel_i];
    if (in_sop_i) begin
      count_d = 9'd1;
    end else if (count_q[in_channel_i] == CNT_MAX) begin
      count_d = count_q[in_channel_i];
    end else begin
      count_d = count_q[in_channel_i] + 9'd1;
    end
    len_err_d = (count_d != {1'b0, numn_d})
              | (int'(numn_d) < CHECK + 1)
              | (int'(numn_d) > N);
  end

  // Accumulator banks, per-channel framing state and the output record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int j = 0; j < CHECK; j++) acc_q[c][j] <= '0;
        count_q[c] <= '0;
        numn_q[c]  <= '0;
      end
      active_q      <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_synd_q    <= '0;
      out_len_err_q <= 1'b0;
    end else begin
      if (upd) begin
        for (int j = 0; j < CHECK; j++) acc_q[in_channel_i][j] <= acc_d[j];
        count_q[in_channel_i]  <= count_d;
        numn_q[in_channel_i]   <= numn_d;
        active_q[in_channel_i] <= ~in_eop_i;
      end
      if (eop_hit) begin
        out_valid_q   <= 1'b1;
        out_channel_q <= in_channel_i;
        for (int j = 0; j < CHECK; j++) out_synd_q[j*M +: M] <= acc_d[j];
        out_len_err_q <= len_err_d;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_channel_o = out_channel_q;
  assign out_synd_o    = out_synd_q;
  assign out_len_err_o = out_len_err_q;

`ifdef RS_SYN_ERASURE_EN
  logic [N-1:0] erapos_q [CHANNELS];
  logic [7:0]   eracnt_q [CHANNELS];
  logic [N-1:0] erapos_d;
  logic [7:0]   eracnt_d;
  logic [N-1:0] out_erapos_q;
  logic [7:0]   out_eracnt_q;
  int           beat_idx;
  int           era_bit;

  // Erased beat k marks degree numn-1-k; negative degrees only count.
  always_comb begin
    beat_idx = in_sop_i ? 0 : int'(count_q[in_channel_i]);
    era_bit  = int'(numn_d) - 1 - beat_idx;
    erapos_d = in_sop_i ? '0 : erapos_q[in_channel_i];
    eracnt_d = in_sop_i ? '0 : eracnt_q[in_channel_i];
    if (in_erasure_i) begin
      if (eracnt_d != 8'hFF) eracnt_d = eracnt_d + 8'd1;
      for (int d = 0; d < N; d++) begin
        if (d == era_bit) erapos_d[d] = 1'b1;
      end
    end
  end

  // Per-channel erasure storage and its copy in the output record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < CHANNELS; c++) begin
        erapos_q[c] <= '0;
        eracnt_q[c] <= '0;
      end
      out_erapos_q <= '0;
      out_eracnt_q <= '0;
    end else begin
      if (upd) begin
        erapos_q[in_channel_i] <= erapos_d;
        eracnt_q[in_channel_i] <= eracnt_d;
      end
      if (eop_hit) begin
        out_erapos_q <= erapos_d;
        out_eracnt_q <= eracnt_d;
      end
    end
  end

  assign out_erapos_o = out_erapos_q;
  assign out_eracnt_o = out_eracnt_q;
`else
  logic unused_erasure;
  assign unused_erasure = in_erasure_i;
  assign out_erapos_o   = '0;
  assign out_eracnt_o   = '0;
`endif

endmodule

// File: tb/tb_rs_syn_mc.sv
// Testbench for rs_syn_mc with default parameters (GF(2^8), poly 285, 32 checks,
// 4 channels). Expected records come from a log/exp-table reference model that
// evaluates each received polynomial directly at every root.
module tb_rs_syn_mc;

  localparam int M         = 8;
  localparam int CHECK     = 32;
  localparam int N         = 255;
  localparam int GENSTART  = 0;
  localparam int ROOTSPACE = 1;
  localparam int CHANNELS  = 4;
  localparam int CHW       = 2;
  localparam int W         = CHW + 1 + 8 + N + CHECK * M;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_sop;
  logic               in_eop;
  logic [CHW-1:0]     in_channel;
  logic [M-1:0]       in_data;
  logic               in_erasure;
  logic [7:0]         in_numn;
  logic               out_valid;
  logic               out_ready;
  logic [CHW-1:0]     out_channel;
  logic [CHECK*M-1:0] out_synd;
  logic               out_len_err;
  logic [7:0]         out_eracnt;
  logic [N-1:0]       out_erapos;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;
  bit rand_ready = 0;
  bit drained;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  logic [7:0] exp_t [256];
  int         log_t [256];
  logic [7:0] wsym  [CHANNELS][256];
  bit         wera  [CHANNELS][256];

  rs_syn_mc dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_sop_i     (in_sop),
    .in_eop_i     (in_eop),
    .in_channel_i (in_channel),
    .in_data_i    (in_data),
    .in_erasure_i (in_erasure),
    .in_numn_i    (in_numn),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_channel_o(out_channel),
    .out_synd_o   (out_synd),
    .out_len_err_o(out_len_err),
    .out_eracnt_o (out_eracnt),
    .out_erapos_o (out_erapos)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random downstream stalls, changed just after the active edge.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- reference model ----------------
  task automatic build_tables();
    logic [7:0] a;
    a = 8'h01;
    for (int i = 0; i < 256; i++) log_t[i] = 0;
    for (int i = 0; i < 255; i++) begin
      exp_t[i]  = a;
      log_t[a]  = i;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    end
    exp_t[255] = 8'h01;
  endtask

  function automatic logic [W-1:0] model(input int c, input int len, input int numn);
    logic [CHECK*M-1:0] s;
    logic [N-1:0]       pos;
    logic [7:0]         ecnt;
    logic [7:0]         acc;
    logic               le;
    int                 e;
    int                 cnt;
    int                 p;
    s = '0;
    for (int j = 0; j < CHECK; j++) begin
      e   = ((GENSTART + j) * ROOTSPACE) % 255;
      acc = 8'h00;
      for (int k = 0; k < len; k++) begin
        if (wsym[c][k] != 8'h00)
          acc = acc ^ exp_t[(log_t[wsym[c][k]] + ((len - 1 - k) * e) % 255) % 255];
      end
      s[j*M +: M] = acc;
    end
    cnt  = (len > N + 1) ? N + 1 : len;
    le   = (cnt != numn) || (numn < CHECK + 1) || (numn > N);
    pos  = '0;
    ecnt = 8'h00;
`ifdef RS_SYN_ERASURE_EN
    for (int k = 0; k < len; k++) begin
      if (wera[c][k]) begin
        if (ecnt != 8'hFF) ecnt = ecnt + 8'd1;
        p = numn - 1 - k;
        if (p >= 0 && p < N) pos = pos | ({{(N-1){1'b0}}, 1'b1} << p);
      end
    end
`endif
    return {CHW'(c), le, ecnt, pos, s};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_got  = {out_channel, out_len_err, out_eracnt, out_erapos, out_synd};
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_record got=%h", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail = n_fail + 1;
          $display("FAIL record ch=%0d got=%h exp=%h", mon_exp[W-1 -: CHW], mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_sop     = 1'b0;
    in_eop     = 1'b0;
    in_erasure = 1'b0;
    in_channel = '0;
    in_data    = '0;
    in_numn    = '0;
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic drive_beat(input int c, input logic [7:0] d, input bit sop, input bit eop,
                            input bit era, input int numn);
    bit ok;
    in_valid   = 1'b1;
    in_channel = CHW'(c);
    in_data    = d;
    in_sop     = sop;
    in_eop     = eop;
    in_erasure = era;
    in_numn    = 8'(numn);
    ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else stalls = stalls + 1;
    end
    if (!ok) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL beat_accept timeout ch=%0d", c);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Drive a word already loaded in wsym/wera for channel c, queueing its record.
  task automatic send_word(input int c, input int len, input int numn);
    for (int k = 0; k < len; k++) begin
      if (k == len - 1) exp_q.push_back(model(c, len, numn));
      drive_beat(c, wsym[c][k], k == 0, k == len - 1, wera[c][k], numn);
    end
  endtask

  task automatic clear_word(input int c);
    for (int k = 0; k < 256; k++) begin
      wsym[c][k] = 8'h00;
      wera[c][k] = 1'b0;
    end
  endtask

  task automatic random_word(input int c);
    for (int k = 0; k < 256; k++) begin
      wsym[c][k] = 8'($urandom_range(0, 255));
      wera[c][k] = 1'b0;
    end
  endtask

  task automatic wait_drain();
    drained = 0;
    for (int t = 0; t < 3000 && !drained; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) drained = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sop    = 1'b1;
    repeat (3) @(negedge clk);
    n_checks = n_checks + 7;
    if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_synd !== '0)      begin n_fail++; $display("FAIL reset_out_synd got=%h exp=0", out_synd); end
    if (out_channel !== '0)   begin n_fail++; $display("FAIL reset_out_channel got=%0d exp=0", out_channel); end
    if (out_len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err got=%b exp=0", out_len_err); end
    if (out_eracnt !== 8'h00) begin n_fail++; $display("FAIL reset_eracnt got=%0d exp=0", out_eracnt); end
    if (out_erapos !== '0)    begin n_fail++; $display("FAIL reset_erapos got=%h exp=0", out_erapos); end
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_word();
    clear_word(0);
    send_word(0, 255, 255);
    n_checks = n_checks + 4;
    if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL zero_latency out_valid got=%b exp=1", out_valid); end
    if (out_synd !== '0)      begin n_fail++; $display("FAIL zero_synd got=%h exp=0", out_synd); end
    if (out_len_err !== 1'b0) begin n_fail++; $display("FAIL zero_len_err got=%b exp=0", out_len_err); end
    if (out_channel !== '0)   begin n_fail++; $display("FAIL zero_channel got=%0d exp=0", out_channel); end
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL zero_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_single_error();
    logic [CHECK*M-1:0] ones;
    logic [CHECK*M-1:0] first;
    ones = {CHECK{8'h01}};
    for (int j = 0; j < CHECK; j++)
      first[j*M +: M] = exp_t[(254 * (GENSTART + j) * ROOTSPACE) % 255];
    clear_word(0);
    wsym[0][254] = 8'h01;
    send_word(0, 255, 255);
    n_checks++;
    if (out_synd !== ones) begin n_fail++; $display("FAIL last_one_synd got=%h exp=%h", out_synd, ones); end
    clear_word(1);
    wsym[1][0] = 8'h01;
    send_word(1, 255, 255);
    n_checks++;
    if (out_synd !== first) begin n_fail++; $display("FAIL first_one_synd got=%h exp=%h", out_synd, first); end
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL single_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < CHANNELS; c++) clear_word(c);
    wsym[2][0] = 8'h01;
    for (int k = 0; k < 255; k++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (k == 254) exp_q.push_back(model(c, 255, 255));
        drive_beat(c, wsym[c][k], k == 0, k == 254, 1'b0, 255);
      end
    end
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL rr_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] cur;
    out_ready = 1'b0;
    random_word(3);
    send_word(3, 40, 40);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      cur = {out_channel, out_len_err, out_eracnt, out_erapos, out_synd};
      n_checks = n_checks + 3;
      if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", t, in_ready); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", t, out_valid); end
      if (cur !== exp_q[0])   begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", t, cur, exp_q[0]); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL bp_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_len_err();
    random_word(0);
    send_word(0, 39, 40);
    n_checks++;
    if (out_len_err !== 1'b1) begin n_fail++; $display("FAIL short_len_err got=%b exp=1", out_len_err); end
    random_word(1);
    send_word(1, 20, 20);
    n_checks++;
    if (out_len_err !== 1'b1) begin n_fail++; $display("FAIL small_numn_len_err got=%b exp=1", out_len_err); end
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL len_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_resync();
    random_word(2);
    for (int k = 0; k < 10; k++) drive_beat(2, wsym[2][k], k == 0, 1'b0, 1'b0, 255);
    random_word(2);
    send_word(2, 40, 40);
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL resync_drain pending=%0d exp=0", exp_q.size()); end
    // Partial codeword cut by reset, then a stray eop on the now-inactive channel.
    random_word(0);
    for (int k = 0; k < 30; k++) drive_beat(0, wsym[0][k], k == 0, 1'b0, 1'b0, 40);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_beat(0, 8'h5A, 1'b0, 1'b1, 1'b0, 40);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_out_valid cyc=%0d got=%b exp=0", t, out_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_erasure();
    logic [N-1:0] pos_exp;
    logic [7:0]   cnt_exp;
`ifdef RS_SYN_ERASURE_EN
    pos_exp = '0;
    pos_exp[254] = 1'b1;
    pos_exp[249] = 1'b1;
    cnt_exp = 8'd2;
`else
    pos_exp = '0;
    cnt_exp = 8'd0;
`endif
    random_word(1);
    wera[1][0] = 1'b1;
    wera[1][5] = 1'b1;
    send_word(1, 255, 255);
    n_checks = n_checks + 2;
    if (out_eracnt !== cnt_exp) begin n_fail++; $display("FAIL era_cnt got=%0d exp=%0d", out_eracnt, cnt_exp); end
    if (out_erapos !== pos_exp) begin n_fail++; $display("FAIL era_pos got=%h exp=%h", out_erapos, pos_exp); end
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL era_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int c;
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      c = i % CHANNELS;
      clear_word(c);
      wsym[c][0] = 8'($urandom_range(0, 255));
      wera[c][0] = 1'($urandom_range(0, 1));
      send_word(c, 1, 1);
    end
    n_checks++;
    if (stalls !== 0) begin n_fail++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
    wait_drain();
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL b2b_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_random();
    int c;
    int len;
    int numn;
    rand_ready = 1;
    for (int i = 0; i < 6; i++) begin
      c    = $urandom_range(0, CHANNELS - 1);
      len  = $urandom_range(33, 80);
      numn = len + $urandom_range(0, 2) - 1;
      random_word(c);
      for (int k = 0; k < len; k++) wera[c][k] = ($urandom_range(0, 7) == 0);
      send_word(c, len, numn);
    end
    wait_drain();
    rand_ready = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n_checks++;
    if (!drained) begin n_fail++; $display("FAIL rand_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    build_tables();
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    test_reset();
    test_zero_word();
    test_single_error();
    test_round_robin();
    test_backpressure();
    test_len_err();
    test_resync();
    test_erasure();
    test_back_to_back();
    test_random();
    repeat (5) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue pending=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_syn_mc.md
# rs_syn_mc

Multi-channel, parametrised serial Reed-Solomon syndrome calculator for the RS decoder front end. It accepts channel-interleaved codeword symbols, one per cycle, and keeps an independent Horner accumulator bank per channel. On end-of-packet it emits the CHECK syndromes together with length-error status and optional erasure data. Its output feeds the key-equation solver through a ready/valid handshake.

## Interface
- BITSPERSYMBOL, 8, symbol width M.
- CHECK, 32, number of syndromes (check symbols).
- IRRPOL, 285, field polynomial of GF(2^M).
- N, 255, maximum codeword length; must be ≤ 2^M−1.
- GENSTART, 0, first root exponent.
- ROOTSPACE, 1, root spacing.
- CHANNELS, 4, independent interleaved channels; must be ≥1. CHW = max(1, clog2(CHANNELS)).
- clk  in  1  single clock; all state is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_sop  in  1  first symbol of a codeword.
- in_eop  in  1  last symbol of a codeword.
- in_channel  in  CHW  channel of the beat.
- in_data  in  M  received symbol, highest degree first.
- in_erasure  in  1  symbol is erased.
- in_numn  in  8  codeword length; sampled on sop beats only.
- out_valid  out  1  syndrome record valid.
- out_ready  in  1  downstream accepts the record.
- out_channel  out  CHW  channel of the record.
- out_synd  out  CHECK*M  S_j in bits [j*M +: M], j = 0..CHECK−1.
- out_len_err  out  1  beat count ≠ latched numn, or numn ∉ [CHECK+1, N].
- out_eracnt  out  8  number of erasures, saturating at 255.
- out_erapos  out  N  bit d set = symbol of degree d erased.

## Operation
- Root r_j = alpha^((GENSTART+j)*ROOTSPACE). Multiply by r_j is a constant GF(2^M) network derived from IRRPOL at elaboration.
- Per channel c, the block keeps: acc[c][0..CHECK−1], count[c] (9 bits), numn[c], active[c], and, with the erasure feature, erapos[c] and eracnt[c].
- Accepted beat with sop on channel c:
  - acc[c][j] = in_data for all j; count = 1; numn latched; active = 1.
  - Any unfinished codeword on c is silently discarded.
- Accepted non-sop beat with active[c] = 1:
  - acc[c][j] = acc[c][j]·r_j ⊕ in_data.
  - count increments, saturating at N+1.
- Accepted non-sop beat with active[c] = 0: beat dropped, no state change.
- Accepted eop beat with active[c] = 1 (sop & eop on one beat is legal):
  - Final accumulator values, after this beat, load the output register.
  - out_len_err = (final count ≠ numn) | numn < CHECK+1 | numn > N.
  - active[c] is cleared.
- Erasure position: an erased beat with beat index k (0 = sop beat) sets erapos bit numn−1−k. If that index is < 0 it is ignored; the count still increments.
- Channels are fully independent. The channel may change on every beat. in_channel ≥ CHANNELS: beat accepted and dropped.

## Timing
- Reset (rst_n low, asynchronous), all outputs and state cleared:
  - out_valid = 0, out_synd = 0, out_channel = 0, out_len_err = 0, out_eracnt = 0, out_erapos = 0.
  - active[*] = 0; in_ready = 0 while rst_n is low.
- in_ready = !out_valid | out_ready. This is combinational and applies to all beats, not only eop beats.
- Latency: eop accepted in cycle t → out_valid = 1 in cycle t+1.
- One record per cycle sustained when out_ready is held high.
- While out_valid & !out_ready, all out_* are held stable.
- Reset mid-codeword discards all partial codewords; no record is emitted.
- Input-side signals are ignored when in_valid = 0 or in_ready = 0.

## Configuration
- RS_SYN_ERASURE_EN defined: in_erasure is honoured, with per-channel erapos/eracnt tracking.
- RS_SYN_ERASURE_EN undefined:
  - in_erasure is ignored; no erasure storage is built.
  - out_eracnt and out_erapos are tied to 0.

## Test plan
- All-zero codeword, N = 255, numn = 255, channel 0 → one cycle after eop: out_synd = 0, out_len_err = 0, out_channel = 0.
- Codeword of 255 symbols, all 0 except last = 0x01 → every S_j = 0x01. All 0 except first = 0x01 → S_j = alpha^(254·(GENSTART+j)·ROOTSPACE).
- Four channels round-robin per beat, with channel 2 carrying the single-error word and the others zero → four records; only channel 2 is nonzero and matches the previous case.
- out_ready held low 10 cycles while out_valid = 1 → in_ready = 0 and outputs stable for 10 cycles. Release → record consumed, in_ready = 1 the same cycle.
- Length and framing errors:
  - numn = 40 with 39 beats → out_len_err = 1.
  - numn = 20 (< CHECK+1) → out_len_err = 1.
  - sop re-issued after 10 beats → only the second codeword is reported.
- With RS_SYN_ERASURE_EN, N = 255, erasures at beats 0 and 5 → out_eracnt = 2, out_erapos bits 254 and 249 set. Without the macro → both fields are 0.
